// File: rtl/exp_align_sched_if.sv
// exp_align_sched_if -- operand/result bundle for the exponent alignment scheduler.
//   master : producer/consumer side (drives mode, operands, in_valid, out_ready)
//   slave  : the scheduler (drives in_ready, out_valid, max/dif results, err_mode)
interface exp_align_sched_if;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] e_bf;
    logic [7:0] c_bf;
    logic [3:0] exp1, exp2, exp3, exp4, exp5, exp6;
    logic [3:0] c_fp;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] max_bf;
    logic [3:0] max_fp;
    logic [7:0] dif_bfe;
    logic [7:0] dif_bfc;
    logic [3:0] dif1, dif2, dif3, dif4, dif5, dif6;
    logic [3:0] difc;
    logic       err_mode;

    modport master (
        output mode, in_valid, e_bf, c_bf, exp1, exp2, exp3, exp4, exp5, exp6,
               c_fp, out_ready,
        input  in_ready, out_valid, max_bf, max_fp, dif_bfe, dif_bfc,
               dif1, dif2, dif3, dif4, dif5, dif6, difc, err_mode
    );

    modport slave (
        input  mode, in_valid, e_bf, c_bf, exp1, exp2, exp3, exp4, exp5, exp6,
               c_fp, out_ready,
        output in_ready, out_valid, max_bf, max_fp, dif_bfe, dif_bfc,
               dif1, dif2, dif3, dif4, dif5, dif6, difc, err_mode
    );
endinterface

// File: rtl/exp_align_sched.sv
// exp_align_sched -- finds the maximum exponent of a BF16 or FP operand bundle
// by scanning one operand per cycle, then produces each operand's alignment
// shift (max - exponent) in a single cycle and holds the result until taken.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : exp_align_sched_if.slave -- mode/operands/in_valid/in_ready on the
//          input side, max/dif results/err_mode/out_valid/out_ready on output.
// Modes: 00 BF16 (e_bf, c_bf), 01 FP 3-product (exp1..exp3, c_fp),
//        11 FP 6-product (exp1..exp6, c_fp), 10 illegal (err_mode result).
module exp_align_sched (
    input  logic                  clk,
    input  logic                  rst,
    exp_align_sched_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DIFF, HOLD} state_t;

    state_t     state_reg, state_next;

    logic [1:0] mode_reg;
    logic [7:0] e_bf_reg, c_bf_reg;
    logic [3:0] fp_reg [6];
    logic [3:0] c_fp_reg;
    logic [7:0] max_reg;
    logic [2:0] cnt_reg;

    logic       out_valid_reg, err_mode_reg;
    logic [7:0] max_bf_reg, dif_bfe_reg, dif_bfc_reg;
    logic [3:0] max_fp_reg, difc_reg;
    logic [3:0] dif_reg [6];

    logic       accept;
    logic [2:0] scan_last;
    logic [7:0] scan_op;
    logic       is_bf, is_fp;
    logic [5:0] fp_use;
    logic [3:0] fp_dif [6];

    assign accept = bus.in_valid && (state_reg == IDLE);
    assign is_bf  = (mode_reg == 2'b00);
    // Modes 01 and 11 are the FP modes; 10 is excluded so it yields zeros.
    assign is_fp  = mode_reg[0];

    // Index of the final operand in the scan order (N-1).
    always_comb begin
        scan_last = 3'd1;
        case (mode_reg)
            2'b01:   scan_last = 3'd3;
            2'b11:   scan_last = 3'd6;
            default: scan_last = 3'd1;
        endcase
    end

    // Operand compared against the running max on this SCAN cycle.
    always_comb begin
        scan_op = 8'd0;
        case (mode_reg)
            2'b00:   scan_op = (cnt_reg == 3'd0) ? e_bf_reg : c_bf_reg;
            2'b01:   scan_op = (cnt_reg == 3'd3) ? {4'd0, c_fp_reg}
                                                 : {4'd0, fp_reg[cnt_reg]};
            2'b11:   scan_op = (cnt_reg == 3'd6) ? {4'd0, c_fp_reg}
                                                 : {4'd0, fp_reg[cnt_reg]};
            default: scan_op = 8'd0;
        endcase
    end

    // Per-product shifts; products beyond the active mode's count read as 0.
    // The running max dominates every scanned operand, so no underflow.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_fp_dif
            localparam bit IN_FP3 = (gi < 3);
            assign fp_use[gi] = (mode_reg == 2'b11) || (IN_FP3 && (mode_reg == 2'b01));
            assign fp_dif[gi] = fp_use[gi] ? (max_reg[3:0] - fp_reg[gi]) : 4'd0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // Illegal mode bypasses SCAN; the DIFF pass loads all-zero results.
            IDLE: if (accept) state_next = (bus.mode == 2'b10) ? DIFF : SCAN;
            SCAN: if (cnt_reg == scan_last) state_next = DIFF;
            DIFF: state_next = HOLD;
            HOLD: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg      <= 2'b00;
            e_bf_reg      <= 8'd0;
            c_bf_reg      <= 8'd0;
            c_fp_reg      <= 4'd0;
            max_reg       <= 8'd0;
            cnt_reg       <= 3'd0;
            out_valid_reg <= 1'b0;
            err_mode_reg  <= 1'b0;
            max_bf_reg    <= 8'd0;
            max_fp_reg    <= 4'd0;
            dif_bfe_reg   <= 8'd0;
            dif_bfc_reg   <= 8'd0;
            difc_reg      <= 4'd0;
            for (int i = 0; i < 6; i++) begin
                fp_reg[i]  <= 4'd0;
                dif_reg[i] <= 4'd0;
            end
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    mode_reg    <= bus.mode;
                    e_bf_reg    <= bus.e_bf;
                    c_bf_reg    <= bus.c_bf;
                    fp_reg[0]   <= bus.exp1;
                    fp_reg[1]   <= bus.exp2;
                    fp_reg[2]   <= bus.exp3;
                    fp_reg[3]   <= bus.exp4;
                    fp_reg[4]   <= bus.exp5;
                    fp_reg[5]   <= bus.exp6;
                    c_fp_reg    <= bus.c_fp;
                    max_reg     <= 8'd0;
                    cnt_reg     <= 3'd0;
                    max_bf_reg  <= 8'd0;
                    max_fp_reg  <= 4'd0;
                    dif_bfe_reg <= 8'd0;
                    dif_bfc_reg <= 8'd0;
                    difc_reg    <= 4'd0;
                    for (int i = 0; i < 6; i++) dif_reg[i] <= 4'd0;
                end
                SCAN: begin
                    if (scan_op > max_reg) max_reg <= scan_op;
                    cnt_reg <= cnt_reg + 3'd1;
                end
                DIFF: begin
                    out_valid_reg <= 1'b1;
                    err_mode_reg  <= (mode_reg == 2'b10);
                    max_bf_reg    <= is_bf ? max_reg : 8'd0;
                    dif_bfe_reg   <= is_bf ? (max_reg - e_bf_reg) : 8'd0;
                    dif_bfc_reg   <= is_bf ? (max_reg - c_bf_reg) : 8'd0;
                    max_fp_reg    <= is_fp ? max_reg[3:0] : 4'd0;
                    difc_reg      <= is_fp ? (max_reg[3:0] - c_fp_reg) : 4'd0;
                    for (int i = 0; i < 6; i++) dif_reg[i] <= fp_dif[i];
                end
                HOLD: if (bus.out_ready) begin
                    out_valid_reg <= 1'b0;
                    err_mode_reg  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.err_mode  = err_mode_reg;
    assign bus.max_bf    = max_bf_reg;
    assign bus.max_fp    = max_fp_reg;
    assign bus.dif_bfe   = dif_bfe_reg;
    assign bus.dif_bfc   = dif_bfc_reg;
    assign bus.dif1      = dif_reg[0];
    assign bus.dif2      = dif_reg[1];
    assign bus.dif3      = dif_reg[2];
    assign bus.dif4      = dif_reg[3];
    assign bus.dif5      = dif_reg[4];
    assign bus.dif6      = dif_reg[5];
    assign bus.difc      = difc_reg;
endmodule

// File: tb/tb_exp_align_sched.sv
// tb_exp_align_sched -- directed bench for exp_align_sched: latency, results
// per mode, unused-output zeroing, illegal mode, hold stability, reset.
module tb_exp_align_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    exp_align_sched_if bus ();

    exp_align_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [7:0] mbf, input logic [3:0] mfp,
                           input logic [7:0] dbe, input logic [7:0] dbc,
                           input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                           input logic [3:0] d4, input logic [3:0] d5, input logic [3:0] d6,
                           input logic [3:0] dc, input logic err);
        chk({tag, ".max_bf"},  {24'd0, bus.max_bf},  {24'd0, mbf});
        chk({tag, ".max_fp"},  {28'd0, bus.max_fp},  {28'd0, mfp});
        chk({tag, ".dif_bfe"}, {24'd0, bus.dif_bfe}, {24'd0, dbe});
        chk({tag, ".dif_bfc"}, {24'd0, bus.dif_bfc}, {24'd0, dbc});
        chk({tag, ".dif1"},    {28'd0, bus.dif1},    {28'd0, d1});
        chk({tag, ".dif2"},    {28'd0, bus.dif2},    {28'd0, d2});
        chk({tag, ".dif3"},    {28'd0, bus.dif3},    {28'd0, d3});
        chk({tag, ".dif4"},    {28'd0, bus.dif4},    {28'd0, d4});
        chk({tag, ".dif5"},    {28'd0, bus.dif5},    {28'd0, d5});
        chk({tag, ".dif6"},    {28'd0, bus.dif6},    {28'd0, d6});
        chk({tag, ".difc"},    {28'd0, bus.difc},    {28'd0, dc});
        chk({tag, ".err_mode"}, {31'd0, bus.err_mode}, {31'd0, err});
    endtask

    task automatic set_ops(input logic [1:0] m, input logic [7:0] eb, input logic [7:0] cb,
                           input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                           input logic [3:0] a4, input logic [3:0] a5, input logic [3:0] a6,
                           input logic [3:0] cf);
        bus.mode = m;
        bus.e_bf = eb; bus.c_bf = cb;
        bus.exp1 = a1; bus.exp2 = a2; bus.exp3 = a3;
        bus.exp4 = a4; bus.exp5 = a5; bus.exp6 = a6;
        bus.c_fp = cf;
    endtask

    // Present the bundle for one edge; in_ready must be high so it is accepted.
    task automatic send(input string tag);
        chk({tag, ".in_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, ".in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
    endtask

    // Count edges after acceptance until out_valid; bounded at 20.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            lat++;
            if (bus.out_valid === 1'b1) break;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        $display("txn %s: out_valid after %0d cycles", tag, lat);
    endtask

    task automatic complete(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".done_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, ".done_in_ready"},  {31'd0, bus.in_ready},  32'd1);
        chk({tag, ".done_err_mode"},  {31'd0, bus.err_mode},  32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_ops(2'b00, 8'd0, 8'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Reset, with in_valid asserted to show rst wins.
        rst = 1'b1;
        bus.in_valid = 1'b1;
        set_ops(2'b10, 8'h11, 8'h22, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7);
        tick();
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk_all("reset", 8'h00, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        tick();
        chk("reset.no_accept", {31'd0, bus.out_valid}, 32'd0);
        $display("txn reset: done");

        // BF16 basic.
        set_ops(2'b00, 8'h7F, 8'h85, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
        send("bf");
        wait_valid("bf", 3);
        chk_all("bf", 8'h85, 4'd0, 8'h06, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        complete("bf");

        // FP 3-product; exp4..6 and BF operands must not influence results.
        set_ops(2'b01, 8'hFF, 8'h10, 4'd3, 4'd9, 4'd5, 4'd15, 4'd14, 4'd13, 4'd7);
        send("fp3");
        wait_valid("fp3", 5);
        chk_all("fp3", 8'h00, 4'd9, 8'h00, 8'h00, 4'd6, 4'd0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd2, 1'b0);
        complete("fp3");

        // FP 6-product; operands scrambled right after acceptance, then a
        // 10-cycle stall with toggling inputs before the result is taken.
        set_ops(2'b11, 8'h40, 8'h41, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15, 4'd0);
        send("fp6");
        set_ops(2'b00, 8'hFF, 8'hFF, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15);
        wait_valid("fp6", 8);
        chk_all("fp6", 8'h00, 4'd15, 8'h00, 8'h00, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd0, 4'd15, 1'b0);
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = c[0];
            set_ops(c[1:0], 8'(c * 37), 8'(c * 11), 4'(c), 4'(c + 1), 4'(c + 2),
                    4'(c + 3), 4'(c + 4), 4'(c + 5), 4'(c + 6));
            tick();
            chk("hold.out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold.in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk_all("hold", 8'h00, 4'd15, 8'h00, 8'h00, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd0, 4'd15, 1'b0);
        end
        bus.in_valid = 1'b0;
        complete("fp6");

        // Illegal mode.
        set_ops(2'b10, 8'h33, 8'h44, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7);
        send("illegal");
        wait_valid("illegal", 1);
        chk_all("illegal", 8'h00, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        complete("illegal");

        // Equal exponents give zero shifts.
        set_ops(2'b01, 8'h00, 8'h00, 4'd7, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 4'd7);
        send("fp3_eq");
        wait_valid("fp3_eq", 5);
        chk_all("fp3_eq", 8'h00, 4'd7, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        complete("fp3_eq");

        set_ops(2'b00, 8'h80, 8'h80, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        send("bf_eq");
        wait_valid("bf_eq", 3);
        chk_all("bf_eq", 8'h80, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        // Reset while holding a result.
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        chk("rst_hold.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_hold.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk_all("rst_hold", 8'h00, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        $display("txn rst_hold: done");

        // Reset on the third SCAN edge of a 6-product bundle.
        set_ops(2'b11, 8'h00, 8'h00, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14);
        send("rst_scan");
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_scan.in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_scan.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk_all("rst_scan", 8'h00, 4'd0, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        $display("txn rst_scan: done");

        // Fresh BF16 bundle after the aborted one.
        set_ops(2'b00, 8'h10, 8'h03, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        send("bf_after");
        wait_valid("bf_after", 3);
        chk_all("bf_after", 8'h10, 4'd0, 8'h00, 8'h0D, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        complete("bf_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
